// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - WIDTH-bit bit-serial subtractor, LSB-first rippled borrow
//
// Latches a (minuend) and b (subtrahend) on an accepted start and produces
// diff = a - b one bit per clock. The borrow out of each bit position is
// carried to the next position through bin_q.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high reset
//   start    - operation request, honoured only while busy is low
//   a, b     - operands, sampled only on the accepting edge
//   busy     - high while bits are being produced
//   done     - one-cycle pulse when diff/borrow/overflow are final
//   diff     - difference register, filled LSB-first
//   bit_out  - difference bit produced on the previous edge
//   bit_vld  - qualifies bit_out, one pulse per produced bit
//   borrow   - final borrow (a < b unsigned)
//   overflow - two's-complement overflow of the subtraction
//
// Build option: define SUB_OVERFLOW_EN to generate the overflow flag;
// without it overflow is tied to 0.
module bit_serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bit_out,
    output logic             bit_vld,
    output logic             borrow,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             bin_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             bit_out_q;
    logic             bit_vld_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] onehot;
    logic             a_bit;
    logic             b_bit;
    logic             d_d;
    logic             bout_d;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] diff_d;

    // Bit selection via a one-hot mask keeps the counter width independent
    // of the operand index width.
    always_comb begin
        onehot = {{(WIDTH-1){1'b0}}, 1'b1} << count_q;
        a_bit  = |(a_q & onehot);
        b_bit  = |(b_q & onehot);
        d_d    = a_bit ^ b_bit ^ bin_q;
        bout_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
        diff_d = diff_q | (onehot & {WIDTH{d_d}});
        last   = (count_q == CNT_W'(WIDTH - 1));
        accept = (state_q != S_RUN) && start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            bin_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            bit_out_q <= 1'b0;
            bit_vld_q <= 1'b0;
            borrow_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_vld_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q      <= a;
                        b_q      <= b;
                        count_q  <= '0;
                        bin_q    <= 1'b0;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else if (state_q == S_DONE) begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    diff_q    <= diff_d;
                    bit_out_q <= d_d;
                    bit_vld_q <= 1'b1;
                    bin_q     <= bout_d;
                    count_q   <= count_q + CNT_W'(1);
                    if (last) begin
                        borrow_q <= bout_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic overflow_q;

    // Signed overflow: operands of differing sign and a result whose sign
    // differs from the minuend. d_d is the result's sign bit on the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (accept) begin
            overflow_q <= 1'b0;
        end else if (state_q == S_RUN && last) begin
            overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d != a_q[WIDTH-1]);
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign diff    = diff_q;
    assign bit_out = bit_out_q;
    assign bit_vld = bit_vld_q;
    assign borrow  = borrow_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - scoreboard bench for bit_serial_subtractor
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bit_out;
    logic         bit_vld;
    logic         borrow;
    logic         overflow;

    bit_serial_subtractor #(.WIDTH(W), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bit_out  (bit_out),
        .bit_vld  (bit_vld),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        int           when;
    } exp_t;

    exp_t sq[$];
    logic bq[$];

    int nvec = 0;
    int nerr = 0;
    bit abort_mode = 1'b0;
    int prev_acc = 0;
    bit prev_keep = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic push_expect(input logic [W-1:0] av, input logic [W-1:0] bv, input int when);
        exp_t e;
        int   ua;
        int   ub;
        int   sd;
        logic [W-1:0] dv;
        ua = int'(av);
        ub = int'(bv);
        dv = W'((ua - ub + 256) % 256);
        sd = int'($signed(av)) - int'($signed(bv));
        e.d  = dv;
        e.br = (ua < ub);
`ifdef SUB_OVERFLOW_EN
        e.ov = (sd > 127) || (sd < -128);
`else
        e.ov = 1'b0;
        if (sd > 1000) e.ov = 1'b1;
`endif
        e.when = when;
        sq.push_back(e);
        for (int i = 0; i < W; i++) bq.push_back(dv[i]);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    initial begin : monitor
        exp_t e;
        logic eb;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (bit_vld === 1'b1 && !abort_mode) begin
                    if (bq.size() == 0) fail("unexpected_bit_vld");
                    else begin
                        eb = bq.pop_front();
                        chk("bit_out", 32'(bit_out), 32'(eb));
                    end
                end
                if (done === 1'b1) begin
                    if (abort_mode) fail("done_after_abort");
                    else if (sq.size() == 0) fail("unexpected_done");
                    else begin
                        e = sq.pop_front();
                        chk("diff", 32'(diff), 32'(e.d));
                        chk("borrow", 32'(borrow), 32'(e.br));
                        chk("overflow", 32'(overflow), 32'(e.ov));
                        chk("done_cycle", 32'(cyc), 32'(e.when));
                        chk("busy_at_done", 32'(busy), 32'd0);
                    end
                end
            end
        end
    end

    // Drive start until the DUT accepts (busy with no bit yet produced).
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep);
        int t;
        start = 1'b1;
        a = av;
        b = bv;
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            t++;
            if (busy === 1'b1 && bit_vld === 1'b0) break;
            if (t > 40) begin
                fail("accept_timeout");
                start = 1'b0;
                return;
            end
        end
        if (prev_keep) chk("b2b_accept_cycle", 32'(cyc), 32'(prev_acc + W + 1));
        prev_acc  = cyc;
        prev_keep = keep;
        push_expect(av, bv, cyc + W);
        if (!keep) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sq.size() != 0 || bq.size() != 0 || busy === 1'b1) && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (t >= 100) fail("drain_timeout");
        @(negedge clk);
        prev_keep = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_bit_vld", 32'(bit_vld), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        op(8'd200, 8'd55, 1'b0);
        drain();
        op(8'd55, 8'd200, 1'b0);
        op(8'h80, 8'h01, 1'b0);
        op(8'h05, 8'h03, 1'b0);
        op(8'h00, 8'h00, 1'b0);
        op(8'hFF, 8'hFF, 1'b0);
        op(8'h00, 8'h01, 1'b0);
        op(8'h7F, 8'hFF, 1'b0);
        drain();

        // Start re-pulsed mid-run must be ignored; then back-to-back ops.
        op(8'd200, 8'd55, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'd1;
        b = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
        op(8'd5, 8'd3, 1'b1);
        op(8'd17, 8'd99, 1'b1);
        op(8'd99, 8'd17, 1'b0);
        drain();

        // Reset mid-run abandons the operation.
        abort_mode = 1'b1;
        start = 1'b1;
        a = 8'd200;
        b = 8'd55;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bit_vld", 32'(bit_vld), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        abort_mode = 1'b0;
        op(8'd9, 8'd9, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
